// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the hazard_ctrl pipeline sequencing controller.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        M_WAIT = 1'b1
    } state_e;

    localparam int unsigned M_TIMEOUT_DEFAULT = 64;
    localparam int unsigned TCNT_W_DEFAULT    = 7;

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_match(
        input logic [4:0] rs1_addr,
        input logic [4:0] rs2_addr,
        input logic       uses_rs1,
        input logic       uses_rs2,
        input logic [4:0] rd_addr
    );
        return (rd_addr != 5'd0) &&
               ((uses_rs1 && (rs1_addr == rd_addr)) ||
                (uses_rs2 && (rs2_addr == rd_addr)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_m_wait_timer.sv
// Wait counter for outstanding M-extension ops; tc flags the last permitted wait cycle.
module m_wait_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned M_TIMEOUT = M_TIMEOUT_DEFAULT,
    parameter int unsigned TCNT_W    = TCNT_W_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TCNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc = (cnt_q == TCNT_W'(M_TIMEOUT - 1));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing for PC, IF/ID and ID/EX, including M-unit launch and wait.
// Optional performance counters are built when HAZARD_CTRL_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned M_TIMEOUT = M_TIMEOUT_DEFAULT,
    parameter int unsigned TCNT_W    = TCNT_W_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic        ex_valid_i,
    input  logic        ex_memread_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_m_instr_i,
    input  logic        ex_redirect_i,
    input  logic        m_done_i,
    output logic        m_start_o,
    output logic        m_busy_o,
    output logic        m_timeout_o,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_stall_o,
    output logic        id_ex_flush_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_events_o
);

    state_e state_q, state_d;
    logic   redirect, m_launch, load_use;
    logic   timer_clr, timer_en, timer_tc;

    assign redirect = ex_redirect_i && ex_valid_i;
    assign m_launch = ex_valid_i && ex_m_instr_i;
    assign load_use = ex_valid_i && ex_memread_i &&
                      load_use_match(id_rs1_addr_i, id_rs2_addr_i,
                                     id_uses_rs1_i, id_uses_rs2_i, ex_rd_addr_i);

    m_wait_timer #(
        .M_TIMEOUT (M_TIMEOUT),
        .TCNT_W    (TCNT_W)
    ) u_m_wait_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (timer_clr),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (!redirect && m_launch) state_d = M_WAIT;
            M_WAIT:  if (m_done_i || timer_tc) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        m_start_o     = 1'b0;
        m_busy_o      = 1'b0;
        m_timeout_o   = 1'b0;
        pc_stall_o    = 1'b0;
        if_id_stall_o = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_stall_o = 1'b0;
        id_ex_flush_o = 1'b0;
        timer_clr     = 1'b0;
        timer_en      = 1'b0;
        if (!rst_i) begin
            case (state_q)
                RUN: begin
                    if (redirect) begin
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end else if (m_launch) begin
                        m_start_o     = 1'b1;
                        pc_stall_o    = 1'b1;
                        if_id_stall_o = 1'b1;
                        id_ex_stall_o = 1'b1;
                        timer_clr     = 1'b1;
                    end else if (load_use) begin
                        pc_stall_o    = 1'b1;
                        if_id_stall_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end
                end
                M_WAIT: begin
                    m_busy_o = 1'b1;
                    timer_en = 1'b1;
                    // Done wins over timeout so a result landing on the last cycle is kept.
                    if (m_done_i) begin
                        m_timeout_o = 1'b0;
                    end else if (timer_tc) begin
                        m_timeout_o = 1'b1;
                    end else begin
                        pc_stall_o    = 1'b1;
                        if_id_stall_o = 1'b1;
                        id_ex_stall_o = 1'b1;
                    end
                end
                default: begin
                    m_busy_o = 1'b0;
                end
            endcase
        end
    end

    redirect_in_m_wait: assert property (@(posedge clk_i) disable iff (rst_i)
        !(state_q == M_WAIT && ex_redirect_i && ex_valid_i));

`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_stall_o)    stall_cnt_q <= stall_cnt_q + 32'd1;
            if (id_ex_flush_o) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_events_o = flush_cnt_q;
`else
    assign stall_cycles_o = '0;
    assign flush_events_o = '0;
`endif

endmodule
